// File: rtl/bit_split_pkg.sv
// Shared ALU constants and the bit_split handshake state encoding.
package bit_split_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_IDXW  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_split_if.sv
// Valid/ready word-in, beat-out bus for bit_split.
interface bit_split_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic [IDXW:0]    out_cnt;

    modport master (
        output in_valid, in0, out_ready,
        input  in_ready, out_valid, out, out_idx, out_last, out_cnt
    );

    modport slave (
        input  in_valid, in0, out_ready,
        output in_ready, out_valid, out, out_idx, out_last, out_cnt
    );
endinterface

// File: rtl/bit_split_lsb_onehot_enc.sv
// Combinational lowest-set-bit isolator: one-hot lowest bit, its index, and a zero flag.
module lsb_onehot_enc #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic [WIDTH-1:0] residue,
    output logic [WIDTH-1:0] lowest,
    output logic [IDXW-1:0]  idx,
    output logic             is_zero
);

    // Two's-complement trick kept at WIDTH bits so bit 31 never spills or sign-extends.
    assign lowest  = residue & ((~residue) + WIDTH'(1));
    assign is_zero = (residue == '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/bit_split.sv
// Splits an accepted word into one-hot beats, lowest set bit first, over valid/ready.
module bit_split
    import bit_split_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int IDXW  = ALU_IDXW
) (
    input logic       clk,
    input logic       rst_n,
    bit_split_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic [IDXW:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] lowest;
    logic [IDXW-1:0]  low_idx;
    logic             res_zero;
    logic             last_beat;

    lsb_onehot_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .residue (residue_q),
        .lowest  (lowest),
        .idx     (low_idx),
        .is_zero (res_zero)
    );

    // An empty word is its own last beat; otherwise last when nothing remains above lowest.
    assign last_beat = res_zero || ((residue_q & ~lowest) == '0);

    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = EMIT;
                    residue_d = bus.in0;
                    cnt_d     = (IDXW+1)'(1);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        residue_d = '0;
                        cnt_d     = '0;
                    end else begin
                        residue_d = residue_q & ~lowest;
                        cnt_d     = cnt_q + (IDXW+1)'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                residue_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            residue_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out       = lowest;
    assign bus.out_idx   = low_idx;
    assign bus.out_last  = (state_q == EMIT) && last_beat;
    assign bus.out_cnt   = cnt_q;

endmodule
